// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the MIPS datapath.
// Single-cycle R-type ops (AND/OR/ADD/SUB/SLT/MFHI/MFLO) complete one edge after
// acceptance. MULTU (shift-add) and DIVU (restoring) iterate WIDTH cycles into HI/LO.
// Build option: define ALU_DIV_EN to compile in the DIV state and the divider;
// without it DIVU is treated as an unknown funct.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
`ifdef ALU_DIV_EN
   localparam logic [5:0] F_DIVU  = 6'd27;
`endif

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ALU_DIV_EN
   localparam logic [1:0] ST_DIV  = 2'd2;
`endif

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Shared iteration register: MUL holds {partial HI, shifting multiplier},
   // DIV holds {remainder, shifting dividend/quotient}.
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   diff;
   logic               slt_bit;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
`ifdef ALU_DIV_EN
   logic [WIDTH:0]     div_shifted;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_step;
`endif

   // Combinational datapath: SLT compare and one multiply/divide iteration.
   always_comb begin
      diff    = dataA - dataB;
      // sign(A-B) corrected by signed overflow of the subtraction
      slt_bit = diff[WIDTH-1] ^ ((dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                                 (diff[WIDTH-1] != dataA[WIDTH-1]));
      mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                 (work_q[0] ? {1'b0, opnd_q} : '0);
      mul_step = {mul_sum, work_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      div_shifted = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_trial   = div_shifted - {1'b0, opnd_q};
      if (!div_trial[WIDTH])
         div_step = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      else
         div_step = {div_shifted[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
`endif
   end

   // Next-state logic: request decode in IDLE, iteration and completion otherwise.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (Signal)
                  F_AND:  out_d = dataA & dataB;
                  F_OR:   out_d = dataA | dataB;
                  F_ADD:  out_d = dataA + dataB;
                  F_SUB:  out_d = diff;
                  F_SLT:  out_d = {{(WIDTH-1){1'b0}}, slt_bit};
                  F_MFHI: out_d = hi_q;
                  F_MFLO: out_d = lo_q;
                  F_MULTU: begin
                     done_d  = 1'b0;
                     state_d = ST_MUL;
                     cnt_d   = '0;
                     work_d  = {{WIDTH{1'b0}}, dataB};
                     opnd_d  = dataA;
                  end
`ifdef ALU_DIV_EN
                  F_DIVU: begin
                     done_d  = 1'b0;
                     state_d = ST_DIV;
                     cnt_d   = '0;
                     work_d  = {{WIDTH{1'b0}}, dataA};
                     opnd_d  = dataB;
                  end
`endif
                  default: out_d = '0;
               endcase
            end
         end
         ST_MUL: begin
            work_d = mul_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = ST_IDLE;
               hi_d    = mul_step[2*WIDTH-1:WIDTH];
               lo_d    = mul_step[WIDTH-1:0];
               out_d   = mul_step[WIDTH-1:0];
               done_d  = 1'b1;
            end
         end
`ifdef ALU_DIV_EN
         ST_DIV: begin
            work_d = div_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = ST_IDLE;
               hi_d    = div_step[2*WIDTH-1:WIDTH];
               lo_d    = div_step[WIDTH-1:0];
               out_d   = div_step[WIDTH-1:0];
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign dataOut = out_q;
   assign done    = done_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH = 32.
// Honours ALU_DIV_EN in the same way as the design.
module tb_alu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [5:0]  Signal;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] dataOut;
   logic        busy;
   logic        done;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_ADD = 6'd32, F_SUB = 6'd34;
   localparam logic [5:0] F_SLT = 6'd42, F_MULTU = 6'd25, F_DIVU = 6'd27;
   localparam logic [5:0] F_MFHI = 6'd16, F_MFLO = 6'd18;

   alu_seq #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .Signal  (Signal),
      .dataA   (dataA),
      .dataB   (dataB),
      .dataOut (dataOut),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Present a request in the current cycle; returns #1 after the accepting edge.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      Signal = op;
      dataA  = a;
      dataB  = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Counts edges after the present one until done is seen (bounded).
   task automatic wait_done(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL rst_dataOut: got %h expected %h", dataOut, 32'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rel_done: got %b expected 0", done); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (done !== 1'b1 || dataOut !== 32'h0) begin n_fail++; $display("FAIL rst_mfhi: got done=%b %h expected done=1 %h", done, dataOut, 32'h0); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (done !== 1'b1 || dataOut !== 32'h0) begin n_fail++; $display("FAIL rst_mflo: got done=%b %h expected done=1 %h", done, dataOut, 32'h0); end
   endtask

   task automatic test_alu_ops;
      logic [5:0]  ops [7];
      logic [31:0] va  [7];
      logic [31:0] vb  [7];
      logic [31:0] ve  [7];
      ops[0] = F_SUB; va[0] = 32'd5;          vb[0] = 32'd7;          ve[0] = 32'hFFFFFFFE;
      ops[1] = F_ADD; va[1] = 32'hFFFFFFFF;   vb[1] = 32'd1;          ve[1] = 32'h0;
      ops[2] = F_SLT; va[2] = 32'h80000000;   vb[2] = 32'h7FFFFFFF;   ve[2] = 32'h1;
      ops[3] = F_SLT; va[3] = 32'h7FFFFFFF;   vb[3] = 32'h80000000;   ve[3] = 32'h0;
      ops[4] = F_AND; va[4] = 32'hF0F0F0F0;   vb[4] = 32'h0FF00FF0;   ve[4] = 32'h00F000F0;
      ops[5] = F_OR;  va[5] = 32'hF0F0F0F0;   vb[5] = 32'h0FF00FF0;   ve[5] = 32'hFFF0FFF0;
      ops[6] = 6'd63; va[6] = 32'h12345678;   vb[6] = 32'h1;          ve[6] = 32'h0;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], va[i], vb[i]);
         n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL op%0d_done: got %b expected 1", i, done); end
         n_cmp++; if (dataOut !== ve[i]) begin n_fail++; $display("FAIL op%0d_result: got %h expected %h", i, dataOut, ve[i]); end
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op%0d_busy: got %b expected 0", i, busy); end
      end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL op_done_drop: got %b expected 0", done); end
   endtask

   task automatic test_multu;
      int edges;
      int nbusy;
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      edges = 0;
      nbusy = 0;
      while (done !== 1'b1 && edges < 200) begin
         if (busy === 1'b1) nbusy++;
         @(posedge clk);
         #1;
         edges++;
      end
      n_cmp++; if (edges != 32) begin n_fail++; $display("FAIL mul_latency: got %0d expected 32", edges); end
      n_cmp++; if (nbusy != 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 32", nbusy); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %b expected 0", busy); end
      n_cmp++; if (dataOut !== 32'h00000001) begin n_fail++; $display("FAIL mul_dataOut: got %h expected %h", dataOut, 32'h1); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_hi: got %h expected %h", dataOut, 32'hFFFFFFFE); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'h00000001) begin n_fail++; $display("FAIL mul_lo: got %h expected %h", dataOut, 32'h1); end
   endtask

   task automatic test_divu;
`ifdef ALU_DIV_EN
      int edges;
      issue(F_DIVU, 32'd100, 32'd7);
      wait_done(edges);
      n_cmp++; if (edges != 32) begin n_fail++; $display("FAIL div_latency: got %0d expected 32", edges); end
      n_cmp++; if (dataOut !== 32'd14) begin n_fail++; $display("FAIL div_dataOut: got %h expected %h", dataOut, 32'd14); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'd14) begin n_fail++; $display("FAIL div_lo: got %h expected %h", dataOut, 32'd14); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'd2) begin n_fail++; $display("FAIL div_hi: got %h expected %h", dataOut, 32'd2); end
      issue(F_DIVU, 32'h1234, 32'h0);
      wait_done(edges);
      n_cmp++; if (dataOut !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected %h", dataOut, 32'hFFFFFFFF); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'h1234) begin n_fail++; $display("FAIL div0_hi: got %h expected %h", dataOut, 32'h1234); end
`else
      issue(F_DIVU, 32'd100, 32'd7);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL nodiv_handshake: got done=%b busy=%b expected done=1 busy=0", done, busy); end
      n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL nodiv_dataOut: got %h expected %h", dataOut, 32'h0); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL nodiv_hi: got %h expected %h", dataOut, 32'hFFFFFFFE); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'h1) begin n_fail++; $display("FAIL nodiv_lo: got %h expected %h", dataOut, 32'h1); end
`endif
   endtask

   task automatic test_busy_protect;
      int edges;
      issue(F_MULTU, 32'd3, 32'd4);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start  = (k >= 5);
         Signal = F_ADD;
         dataA  = 32'd1;
         dataB  = 32'd1;
         @(posedge clk);
         #1;
         if (k >= 5) begin
            n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL bp_ignore_c%0d: got busy=%b done=%b expected busy=1 done=0", k, busy, done); end
         end
      end
      start = 1'b0;
      wait_done(edges);
      n_cmp++; if (edges + 10 != 32) begin n_fail++; $display("FAIL bp_latency: got %0d expected 32", edges + 10); end
      n_cmp++; if (dataOut !== 32'd12) begin n_fail++; $display("FAIL bp_lo: got %h expected %h", dataOut, 32'd12); end
      issue(F_ADD, 32'd1, 32'd1);
      n_cmp++; if (done !== 1'b1 || dataOut !== 32'd2) begin n_fail++; $display("FAIL bp_b2b_add: got done=%b %h expected done=1 %h", done, dataOut, 32'd2); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'd12) begin n_fail++; $display("FAIL bp_mflo: got %h expected %h", dataOut, 32'd12); end
   endtask

   task automatic test_reset_mid;
      int edges;
      bit seen_done;
      issue(F_MULTU, 32'd2, 32'h80000001);
      wait_done(edges);
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'd1) begin n_fail++; $display("FAIL rm_prime_hi: got %h expected %h", dataOut, 32'd1); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'd2) begin n_fail++; $display("FAIL rm_prime_lo: got %h expected %h", dataOut, 32'd2); end
      issue(F_MULTU, 32'd7, 32'd9);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b expected 0", done); end
      n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL rm_dataOut: got %h expected %h", dataOut, 32'h0); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done) begin n_fail++; $display("FAIL rm_no_done: got 1 expected 0"); end
      issue(F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL rm_mflo: got %h expected %h", dataOut, 32'h0); end
      issue(F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL rm_mfhi: got %h expected %h", dataOut, 32'h0); end
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      Signal = 6'd0;
      dataA  = 32'h0;
      dataB  = 32'h0;
      test_reset();
      test_alu_ops();
      test_multu();
      test_divu();
      test_busy_protect();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
